// File: rtl/vixen_fetch_pc_gen_pkg.sv
// Shared types and helpers for the two-thread fetch PC generator.
// Holds the per-thread state enum, the fetch request bundle and next-PC helper.
package vixen_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        SHADOW = 2'd2
    } thread_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic        thread;
    } fetch_req_t;

    // Start of the next fetch block: align down, then step one block.
    function automatic logic [63:0] seq_next_pc(
        input logic [63:0] pc,
        input int unsigned fetch_bytes
    );
        logic [63:0] fb;
        fb = 64'(fetch_bytes);
        return (pc & ~(fb - 64'd1)) + fb;
    endfunction

endpackage

// File: rtl/vixen_fetch_pc_gen_if.sv
// Fetch request channel between the PC generator and the I-cache.
// Ports: valid/req (generator -> cache), ready (cache -> generator).
interface vixen_fetch_pc_gen_if;
    import vixen_fetch_pkg::*;

    logic       valid;
    logic       ready;
    fetch_req_t req;

    modport master (
        output valid,
        output req,
        input  ready
    );

    modport slave (
        input  valid,
        input  req,
        output ready
    );

endinterface

// File: rtl/vixen_fetch_pc_gen_thread_ctx.sv
// One thread's fetch context: state FSM, PC register and next-PC mux.
// Ports: clk/rst, enable, redirect (+pc), accept, bp_hit/bp_target in;
//        is_ready, is_active, pred_used, pc out.
module vixen_fetch_thread_ctx
    import vixen_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned FETCH_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        accept,
    input  logic        bp_hit,
    input  logic [63:0] bp_target,
    output logic        is_ready,
    output logic        is_active,
    output logic        pred_used,
    output logic [63:0] pc
);

    thread_state_e state_q;
    thread_state_e state_d;
    logic [63:0]   pc_q;
    logic [63:0]   pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Disable beats redirect for state, but a redirect still lands its PC.
    // Redirect beats the shadow-cycle prediction.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pred_used = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            if (redirect) begin
                pc_d = redirect_pc;
            end
        end else if (redirect) begin
            pc_d = redirect_pc;
            if (state_q != IDLE) begin
                state_d = READY;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = READY;
                end
                READY: begin
                    if (accept) begin
                        state_d = SHADOW;
                    end
                end
                SHADOW: begin
                    state_d = READY;
                    if (bp_hit) begin
                        pc_d      = bp_target;
                        pred_used = 1'b1;
                    end else begin
                        pc_d = seq_next_pc(pc_q, FETCH_BYTES);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign is_ready  = (state_q == READY);
    assign is_active = (state_q != IDLE);
    assign pc        = pc_q;

endmodule

// File: rtl/vixen_fetch_pc_gen.sv
// Two-thread fetch PC generator: round-robin arbiter with request lock,
// predictor steering, backend redirect and performance counters.
// Ports: clk/rst, thread_enable, redirect_*, fetch (master channel),
//        pc_t0/pc_t1/thread_active to predictor, bp_* from predictor, perf_*.
module vixen_fetch_pc_gen
    import vixen_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR_T0 = 64'h0000_0000_0000_1000,
    parameter logic [63:0] RESET_VECTOR_T1 = 64'h0000_0000_0000_2000,
    parameter int unsigned FETCH_BYTES     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 thread_enable,
    input  logic                       redirect_valid,
    input  logic                       redirect_thread,
    input  logic [63:0]                redirect_pc,
    vixen_fetch_pc_gen_if.master       fetch,
    output logic [63:0]                pc_t0,
    output logic [63:0]                pc_t1,
    output logic [1:0]                 thread_active,
    input  logic                       bp_taken,
    input  logic [63:0]                bp_target,
    input  logic                       bp_valid,
    output logic [31:0]                perf_fetches,
    output logic [31:0]                perf_pred_taken,
    output logic [31:0]                perf_redirects
);

    logic [1:0]  redir_hit;
    logic [1:0]  is_ready;
    logic [1:0]  cand;
    logic [1:0]  acc_vec;
    logic [1:0]  pred_used;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic        bp_hit;
    logic        sel;
    logic        lock_hit;
    logic        req_valid;
    logic        req_thread;
    logic [63:0] req_pc;
    logic        accept;

    logic        lock_q;
    logic        lock_thr_q;
    logic        rr_last_q;

    assign redir_hit = {redirect_valid & redirect_thread,
                        redirect_valid & ~redirect_thread};
    assign bp_hit    = bp_valid & bp_taken;

    // A thread being redirected this cycle cannot offer; this is what
    // retracts a pending request on redirect.
    assign cand = is_ready & ~redir_hit;

    assign lock_hit = lock_q & cand[lock_thr_q] & thread_enable[lock_thr_q];

    always_comb begin
        sel = 1'b0;
        if (lock_hit) begin
            sel = lock_thr_q;
        end else if (&cand) begin
            sel = ~rr_last_q;
        end else if (cand[1]) begin
            sel = 1'b1;
        end
    end

    assign req_valid  = |cand;
    assign req_thread = req_valid ? sel : 1'b0;
    assign req_pc     = !req_valid ? 64'h0 :
                        (sel ? pc1 : pc0);
    assign accept     = req_valid & fetch.ready;
    assign acc_vec    = {accept & sel, accept & ~sel};

    assign fetch.valid      = req_valid;
    assign fetch.req.pc     = req_pc;
    assign fetch.req.thread = req_thread;

    assign pc_t0 = req_pc;
    assign pc_t1 = req_thread ? pc0 : pc1;

    vixen_fetch_thread_ctx #(
        .RESET_PC    (RESET_VECTOR_T0),
        .FETCH_BYTES (FETCH_BYTES)
    ) u_t0 (
        .clk         (clk),
        .rst         (rst),
        .enable      (thread_enable[0]),
        .redirect    (redir_hit[0]),
        .redirect_pc (redirect_pc),
        .accept      (acc_vec[0]),
        .bp_hit      (bp_hit),
        .bp_target   (bp_target),
        .is_ready    (is_ready[0]),
        .is_active   (thread_active[0]),
        .pred_used   (pred_used[0]),
        .pc          (pc0)
    );

    vixen_fetch_thread_ctx #(
        .RESET_PC    (RESET_VECTOR_T1),
        .FETCH_BYTES (FETCH_BYTES)
    ) u_t1 (
        .clk         (clk),
        .rst         (rst),
        .enable      (thread_enable[1]),
        .redirect    (redir_hit[1]),
        .redirect_pc (redirect_pc),
        .accept      (acc_vec[1]),
        .bp_hit      (bp_hit),
        .bp_target   (bp_target),
        .is_ready    (is_ready[1]),
        .is_active   (thread_active[1]),
        .pred_used   (pred_used[1]),
        .pc          (pc1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_thr_q <= 1'b0;
            rr_last_q  <= 1'b1;
        end else begin
            lock_q     <= req_valid & ~fetch.ready;
            lock_thr_q <= sel;
            if (accept) begin
                rr_last_q <= sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetches    <= 32'd0;
            perf_pred_taken <= 32'd0;
            perf_redirects  <= 32'd0;
        end else begin
            if (accept) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
            if (|pred_used) begin
                perf_pred_taken <= perf_pred_taken + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end

endmodule

// File: doc/vixen_fetch_pc_gen.md
# vixen_fetch_pc_gen

Two-thread fetch PC generator, directly upstream and downstream of `vixen_branch_predictor`. It holds one fetch PC per thread and arbitrates round-robin between the threads. It issues fetch requests to the I-cache over a valid/ready handshake and drives the predictor's `pc_t0`/`pc_t1`/`thread_active`. It then consumes the predictor's `bp_taken`/`bp_target` one cycle later to steer each thread's next PC. A backend redirect (mispredict or exception) overrides everything.

## Interface
- `RESET_VECTOR_T0`, 64'h0000_0000_0000_1000: thread 0 PC after reset.
- `RESET_VECTOR_T1`, 64'h0000_0000_0000_2000: thread 1 PC after reset.
- `FETCH_BYTES`, 16: fetch block size; power of two, 4..64.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `thread_enable`  in  2: per-thread run enable.
- `redirect_valid`  in  1: backend redirect strobe.
- `redirect_thread`  in  1: redirect target thread.
- `redirect_pc`  in  64: new PC.
- `fetch_valid`  out  1: request offered.
- `fetch_ready`  in  1: I-cache accepts.
- `fetch_pc`  out  64: request PC; 0 when `fetch_valid`=0.
- `fetch_thread`  out  1: request thread.
- `pc_t0`  out  64: to predictor; equals `fetch_pc`.
- `pc_t1`  out  64: to predictor; PC register of the thread not selected.
- `thread_active`  out  2: bit set when that thread is not IDLE.
- `bp_taken`  in  1; `bp_target`  in  64; `bp_valid`  in  1: predictor outputs, one cycle after `pc_t0`.
- `perf_fetches`, `perf_pred_taken`, `perf_redirects`  out  32 each: wrapping counters.

## Operation
- Per-thread FSM:
  - IDLE → READY when its `thread_enable` bit is 1.
  - READY → SHADOW on an accepted request (`fetch_valid && fetch_ready` for that thread).
  - SHADOW → READY unconditionally next cycle.
  - Any state → IDLE on the cycle after its enable bit reads 0; a prediction pending in SHADOW is discarded.
- SHADOW resolution, in the cycle after acceptance:
  - If `bp_valid && bp_taken`, PC ← `bp_target` and `perf_pred_taken`++.
  - Otherwise PC ← sequential next: (PC & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^64.
  - A thread in SHADOW never issues, so a single thread fetches at most every other cycle; two threads interleave at full rate.
- Redirect:
  - PC[`redirect_thread`] ← `redirect_pc` (used unaligned as-is); `perf_redirects`++.
  - A READY or SHADOW thread goes to READY; an IDLE thread stays IDLE but its PC is updated.
  - Redirect beats a same-cycle prediction.
  - Redirect combinationally masks `fetch_valid` when `fetch_thread` == `redirect_thread`, so the request is retracted and not counted. This is the only allowed retraction.
- Arbitration:
  - Candidates are threads in READY that are not being redirected this cycle.
  - If both are candidates, pick the thread opposite `rr_last`. `rr_last` updates only on accept and resets to 1, so thread 0 wins first.
  - Lock: an offered but unaccepted request keeps the same thread and PC next cycle. Only redirect or disable of that thread breaks the lock.
- Counters: `perf_fetches`++ per accept. All counters wrap at 2^32.

## Timing
- Reset values:
  - `fetch_valid`=0, `fetch_pc`=0, `pc_t0`=0.
  - `pc_t1`=`RESET_VECTOR_T1`, `thread_active`=0.
  - All counters 0; both threads IDLE; PCs at their reset vectors; lock clear.
- Enable set in cycle N → READY in N+1 → `fetch_valid` in N+1 (combinational from state).
- Accept at N → SHADOW at N+1 (prediction sampled at N+1) → new PC and READY at N+2.
- Redirect at N → PC visible and issuable at N+1.
- `bp_*` are ignored when no thread is in SHADOW.
- Reset asserted mid-operation forces all reset values asynchronously; any pending prediction is lost.

## Structure
- Package `vixen_fetch_pkg`:
  - `thread_state_e` {IDLE, READY, SHADOW}.
  - `fetch_req_t` {pc, thread}.
  - Function `seq_next_pc(pc, fetch_bytes)`.
- Sub-module `vixen_fetch_thread_ctx`, instantiated twice:
  - Contains the FSM, PC register and next-PC mux (redirect > prediction > hold).
  - Outputs `is_ready`, `pc`.
- Top level holds the arbiter, lock register, `rr_last`, output muxing and counters.

## Test plan
- Reset, then `thread_enable`=01 with `fetch_ready`=1 and `bp_taken`=0 → `fetch_pc` 0x1000, 0x1010, 0x1020 on cycles 1, 3, 5; `fetch_valid` low on cycles 2, 4.
- `thread_enable`=11, `fetch_ready`=1 → threads alternate 0,1,0,1 every cycle; PCs are 0x1000, 0x2000, 0x1010, 0x2010.
- Thread 0 accepted at 0x1000, next cycle `bp_valid`=1, `bp_taken`=1, `bp_target`=0x4000 → next thread 0 `fetch_pc`=0x4000 and `perf_pred_taken`=1.
- Hold `fetch_ready`=0 for 3 cycles while thread 1 READY → `fetch_thread` and `fetch_pc` stay stable; accept on cycle 4 only.
- Redirect thread 0 to 0x8002 while its request is pending and a taken prediction arrives the same cycle → `fetch_valid` drops that cycle; next `fetch_pc`=0x8002; the following sequential fetch is 0x8010.
- Pulse `rst` mid-stream with both threads running → `fetch_valid`=0 and `thread_active`=0 immediately; after release and enable, thread 0 refetches 0x1000.
